hist_frame_controller: RTL and testbench

HIST_FRAME_CONTROLLER -- requirements
Module: hist_frame_controller

---
 rtl/hist_frame_controller_pkg.sv | 25 ++
 rtl/hist_cdf_accumulator.sv | 67 ++++++
 rtl/hist_frame_controller.sv | 172 +++++++++++++++++
 tb/tb_hist_frame_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_frame_controller_pkg.sv
// Shared sizing defaults and state encodings for the histogram frame controller
// and its CDF accumulator.
package hist_frame_controller_pkg;

  localparam int DEF_BIN_CNT = 256;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_CDF_W   = 24;

  // Calculator address space holds two banks of bins; readout index is one bank wide.
  localparam int ADDR_W = 9;
  localparam int BIN_W  = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } col_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_CAP  = 2'd2,
    RD_OUT  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/hist_cdf_accumulator.sv
// Running cumulative sum over one histogram bank: saturating adder, bin index
// counter and the registered CDF output.
module hist_cdf_accumulator
  import hist_frame_controller_pkg::*;
#(
  parameter int BIN_CNT = DEF_BIN_CNT,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int CDF_W   = DEF_CDF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             capture,
  input  logic             advance,
  input  logic [CNT_W-1:0] rd_data,
  output logic [CDF_W-1:0] cdf_data,
  output logic [BIN_W-1:0] cdf_bin,
  output logic             cdf_valid,
  output logic             cdf_last
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BIN_CNT - 1);

  // Unsigned add with clamp to all-ones; counts are never negative so one carry bit suffices.
  function automatic logic [CDF_W-1:0] sat_add(input logic [CDF_W-1:0] acc,
                                               input logic [CNT_W-1:0] inc);
    logic [CDF_W:0] sum;
    sum = {1'b0, acc} + {{(CDF_W + 1 - CNT_W){1'b0}}, inc};
    return sum[CDF_W] ? {CDF_W{1'b1}} : sum[CDF_W-1:0];
  endfunction

  logic [CDF_W-1:0] acc_r;
  logic [BIN_W-1:0] idx_r;
  logic             valid_r;
  logic             last_r;

  // Sum, index and output flags; the sum register is presented directly as cdf_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r   <= {CDF_W{1'b0}};
      idx_r   <= {BIN_W{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (clear) begin
      acc_r   <= {CDF_W{1'b0}};
      idx_r   <= {BIN_W{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (capture) begin
      acc_r   <= sat_add(acc_r, rd_data);
      valid_r <= 1'b1;
      last_r  <= (idx_r == LAST_BIN);
    end else if (advance) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      if (idx_r != LAST_BIN) begin
        idx_r <= idx_r + BIN_W'(1);
      end
    end
  end

  assign cdf_data  = acc_r;
  assign cdf_bin   = idx_r;
  assign cdf_valid = valid_r;
  assign cdf_last  = last_r;

endmodule

// File: rtl/hist_frame_controller.sv
// Frame gating, ping-pong bank selection and CDF readout sequencing that sits
// beside a dual-bank histogram calculator.
module hist_frame_controller
  import hist_frame_controller_pkg::*;
#(
  parameter int BIN_CNT = DEF_BIN_CNT,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int CDF_W   = DEF_CDF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic              frame_end,
  output logic              hist_in_valid,
  output logic [ADDR_W-1:0] hist_base_address,
  output logic              hist_end_of_frame,
  output logic [ADDR_W-1:0] hist_rd_addr,
  input  logic [CNT_W-1:0]  hist_rd_data,
  output logic [CDF_W-1:0]  cdf_data,
  output logic [BIN_W-1:0]  cdf_bin,
  output logic              cdf_valid,
  input  logic              cdf_ready,
  output logic              cdf_last,
  output logic              busy,
  output logic              overrun_err
);

  localparam logic [ADDR_W-1:0] BANK0_BASE = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(BIN_CNT);
  localparam logic [BIN_W-1:0]  LAST_BIN   = BIN_W'(BIN_CNT - 1);

  col_state_t        col_state_r;
  col_state_t        col_state_s;
  rd_state_t         rd_state_r;
  rd_state_t         rd_state_s;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] rd_base_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              overrun_r;
  logic              eof_s;
  logic              start_s;
  logic              handshake_s;
  logic              capture_s;
  logic              advance_s;

  // Collect FSM: pixel gating and end-of-frame forwarding (frame_end beats frame_start).
  always_comb begin
    col_state_s   = col_state_r;
    hist_in_valid = 1'b0;
    eof_s         = 1'b0;
    case (col_state_r)
      IDLE: begin
        if (frame_start) begin
          col_state_s = COLLECT;
        end else begin
          col_state_s = IDLE;
        end
      end
      COLLECT: begin
        hist_in_valid = pix_valid;
        eof_s         = frame_end;
        if (frame_end) begin
          col_state_s = IDLE;
        end else begin
          col_state_s = COLLECT;
        end
      end
      default: begin
        col_state_s = IDLE;
      end
    endcase
  end

  // A closed frame only swaps banks when the previous readout has drained.
  assign start_s     = eof_s && (rd_state_r == RD_IDLE);
  assign handshake_s = cdf_valid && cdf_ready;

  // Readout FSM: address, capture, then hold the output until accepted.
  always_comb begin
    rd_state_s = rd_state_r;
    capture_s  = 1'b0;
    advance_s  = 1'b0;
    case (rd_state_r)
      RD_IDLE: begin
        if (start_s) begin
          rd_state_s = RD_ADDR;
        end else begin
          rd_state_s = RD_IDLE;
        end
      end
      RD_ADDR: begin
        rd_state_s = RD_CAP;
      end
      RD_CAP: begin
        capture_s  = 1'b1;
        rd_state_s = RD_OUT;
      end
      RD_OUT: begin
        if (handshake_s) begin
          advance_s = 1'b1;
          if (cdf_bin != LAST_BIN) begin
            rd_state_s = RD_ADDR;
          end else begin
            rd_state_s = RD_IDLE;
          end
        end else begin
          rd_state_s = RD_OUT;
        end
      end
      default: begin
        rd_state_s = RD_IDLE;
      end
    endcase
  end

  // State registers for both FSMs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_state_r <= IDLE;
      rd_state_r  <= RD_IDLE;
    end else begin
      col_state_r <= col_state_s;
      rd_state_r  <= rd_state_s;
    end
  end

  // Bank toggle, readout address generation and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r    <= BANK0_BASE;
      rd_base_r <= BANK0_BASE;
      rd_addr_r <= {ADDR_W{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      if (start_s) begin
        base_r    <= (base_r == BANK0_BASE) ? BANK1_BASE : BANK0_BASE;
        rd_base_r <= base_r;
        rd_addr_r <= base_r;
      end else if (advance_s && (cdf_bin != LAST_BIN)) begin
        rd_addr_r <= rd_base_r + ADDR_W'(cdf_bin) + ADDR_W'(1);
      end
      if (eof_s && !start_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  hist_cdf_accumulator #(
    .BIN_CNT (BIN_CNT),
    .CNT_W   (CNT_W),
    .CDF_W   (CDF_W)
  ) u_cdf_acc (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_s),
    .capture   (capture_s),
    .advance   (advance_s),
    .rd_data   (hist_rd_data),
    .cdf_data  (cdf_data),
    .cdf_bin   (cdf_bin),
    .cdf_valid (cdf_valid),
    .cdf_last  (cdf_last)
  );

  assign hist_base_address = base_r;
  assign hist_end_of_frame = eof_s;
  assign hist_rd_addr      = rd_addr_r;
  assign busy              = (rd_state_r != RD_IDLE);
  assign overrun_err       = overrun_r;

endmodule

// File: tb/tb_hist_frame_controller.sv
// Directed-plus-random bench: a behavioural dual-bank histogram calculator sits
// beside two controllers (24-bit and 16-bit CDF) and a spec-level model predicts the CDF.
module tb_hist_frame_controller;

  logic        clk = 1'b0;
  logic        rst, frame_start, pix_valid, frame_end, cdf_ready;
  logic [7:0]  pix_val;
  logic        hist_in_valid, hist_end_of_frame, cdf_valid, cdf_last, busy, overrun_err;
  logic [8:0]  hist_base_address, hist_rd_addr;
  logic [15:0] hist_rd_data;
  logic [23:0] cdf_data;
  logic [7:0]  cdf_bin;
  logic        b_in_valid, b_eof, b_cdf_valid, b_cdf_last, b_busy, b_overrun;
  logic [8:0]  b_base, b_rd_addr;
  logic [15:0] b_cdf_data;
  logic [7:0]  b_cdf_bin;

  int     mem [512];
  int     exp_mem [512];
  logic   fill_req;
  int     fill_val;
  int     exp_base, rd_bank, got;
  bit     armed, exp_busy, exp_overrun;
  int     pass_cnt = 0;
  int     total_cnt = 0;
  longint cyc = 0;
  longint acc_cyc [256];
  logic [23:0] obs_a [256];
  logic [15:0] obs_b [256];

  always #5 clk = ~clk;

  hist_frame_controller dut_a (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .frame_end(frame_end), .hist_in_valid(hist_in_valid),
    .hist_base_address(hist_base_address), .hist_end_of_frame(hist_end_of_frame),
    .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data), .cdf_data(cdf_data),
    .cdf_bin(cdf_bin), .cdf_valid(cdf_valid), .cdf_ready(cdf_ready),
    .cdf_last(cdf_last), .busy(busy), .overrun_err(overrun_err)
  );

  hist_frame_controller #(.CDF_W(16)) dut_b (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .frame_end(frame_end), .hist_in_valid(b_in_valid),
    .hist_base_address(b_base), .hist_end_of_frame(b_eof),
    .hist_rd_addr(b_rd_addr), .hist_rd_data(hist_rd_data), .cdf_data(b_cdf_data),
    .cdf_bin(b_cdf_bin), .cdf_valid(b_cdf_valid), .cdf_ready(cdf_ready),
    .cdf_last(b_cdf_last), .busy(b_busy), .overrun_err(b_overrun)
  );

  // Behavioural calculator: counts gated pixels into the active bank, 1-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    hist_rd_data <= 16'(mem[hist_rd_addr]);
    if (fill_req) begin
      for (int i = 0; i < 512; i++) mem[i] <= fill_val;
    end else if (hist_in_valid) begin
      mem[int'(hist_base_address) + int'(pix_val)] <= mem[int'(hist_base_address) + int'(pix_val)] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Cumulative count through 'bin' of a bank, clamped to the CDF width.
  function automatic longint exp_cdf(input int bank, input int bin, input int w);
    longint s;
    longint mx;
    s  = 0;
    mx = (longint'(1) << w) - 1;
    for (int i = 0; i <= bin; i++) s += longint'(exp_mem[bank + i]) & 64'hFFFF;
    return (s > mx) ? mx : s;
  endfunction

  task automatic fill(input int v);
    fill_val = v;
    fill_req = 1'b1;
    for (int i = 0; i < 512; i++) exp_mem[i] = v;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    armed = 1'b1;
  endtask

  task automatic send_pix(input int p, input bit v);
    pix_val   = 8'(p);
    pix_valid = v;
    #1;
    chk("hist_in_valid", {63'd0, hist_in_valid}, {63'd0, armed & v});
    chk("hist_in_valid_b", {63'd0, b_in_valid}, {63'd0, armed & v});
    if (armed && v) exp_mem[exp_base + p]++;
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic rand_frame(input int n);
    for (int i = 0; i < n; i++) send_pix(int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
  endtask

  task automatic end_frame(input bit also_start);
    bit fwd;
    bit swap;
    fwd  = armed;
    swap = armed && !exp_busy;
    frame_end   = 1'b1;
    frame_start = also_start;
    #1;
    chk("hist_end_of_frame", {63'd0, hist_end_of_frame}, {63'd0, fwd});
    chk("hist_end_of_frame_b", {63'd0, b_eof}, {63'd0, fwd});
    @(negedge clk);
    frame_end   = 1'b0;
    frame_start = 1'b0;
    if (swap) begin
      rd_bank  = exp_base;
      exp_base = (exp_base == 0) ? 256 : 0;
      exp_busy = 1'b1;
      got      = 0;
    end else if (fwd) begin
      exp_overrun = 1'b1;
    end
    armed = 1'b0;
    chk("hist_base_address", 64'(hist_base_address), 64'(exp_base));
    chk("hist_base_address_b", 64'(b_base), 64'(exp_base));
    chk("overrun_err", {63'd0, overrun_err}, {63'd0, exp_overrun});
    chk("overrun_err_b", {63'd0, b_overrun}, {63'd0, exp_overrun});
    chk("busy_after_eof", {63'd0, busy}, {63'd0, exp_busy});
  endtask

  // Consume bins until 'upto' are accepted; optional random ready and a 10-cycle stall.
  task automatic read_bins(input int upto, input bit rnd, input int stall_bin);
    int          guard;
    logic [23:0] held_d;
    logic [8:0]  held_a;
    guard = 0;
    while (got < upto && guard < 4000) begin
      cdf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cdf_valid) begin
        chk("cdf_data", 64'(cdf_data), 64'(exp_cdf(rd_bank, got, 24)));
        chk("cdf_data_sat16", 64'(b_cdf_data), 64'(exp_cdf(rd_bank, got, 16)));
        chk("cdf_bin", 64'(cdf_bin), 64'(got));
        chk("cdf_bin_b", 64'(b_cdf_bin), 64'(got));
        chk("cdf_last", {63'd0, cdf_last}, {63'd0, got == 255});
        chk("cdf_last_b", {63'd0, b_cdf_last}, {63'd0, got == 255});
        chk("hist_rd_addr", 64'(hist_rd_addr), 64'(rd_bank + got));
        chk("hist_rd_addr_b", 64'(b_rd_addr), 64'(rd_bank + got));
        chk("cdf_valid_b", {63'd0, b_cdf_valid}, 64'd1);
        chk("busy_readout", {63'd0, busy}, 64'd1);
        if (got == stall_bin) begin
          cdf_ready = 1'b0;
          held_d    = cdf_data;
          held_a    = hist_rd_addr;
          repeat (10) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, cdf_valid}, 64'd1);
            chk("stall_data", 64'(cdf_data), 64'(held_d));
            chk("stall_bin", 64'(cdf_bin), 64'(stall_bin));
            chk("stall_addr", 64'(hist_rd_addr), 64'(held_a));
          end
          cdf_ready = 1'b1;
          stall_bin = -1;
        end
        if (cdf_ready) begin
          obs_a[got]   = cdf_data;
          obs_b[got]   = b_cdf_data;
          acc_cyc[got] = cyc;
          got++;
        end
      end
      @(negedge clk);
      guard++;
    end
    chk("readout_progress", 64'(got), 64'(upto));
    if (got == 256 && exp_busy) begin
      exp_busy = 1'b0;
      chk("busy_done", {63'd0, busy}, 64'd0);
      chk("busy_done_b", {63'd0, b_busy}, 64'd0);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cdf_valid", {63'd0, cdf_valid}, 64'd0);
    chk("rst_cdf_valid_b", {63'd0, b_cdf_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_busy_b", {63'd0, b_busy}, 64'd0);
    chk("rst_base", 64'(hist_base_address), 64'd0);
    chk("rst_rd_addr", 64'(hist_rd_addr), 64'd0);
    chk("rst_cdf_data", 64'(cdf_data), 64'd0);
    chk("rst_cdf_bin", 64'(cdf_bin), 64'd0);
    chk("rst_cdf_last", {63'd0, cdf_last}, 64'd0);
    chk("rst_overrun", {63'd0, overrun_err}, 64'd0);
    chk("rst_eof", {63'd0, hist_end_of_frame}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; frame_end = 1'b0;
    pix_val = 8'd0; cdf_ready = 1'b1; fill_req = 1'b0; fill_val = 0;
    exp_base = 0; rd_bank = 0; got = 0; armed = 1'b0; exp_busy = 1'b0; exp_overrun = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    fill(0);

    // Pixels and frame_end before any frame_start are ignored.
    send_pix(7, 1'b1);
    end_frame(1'b0);

    // Reference frame with ready held high: fixed CDF and 3-cycle throughput.
    start_frame();
    send_pix(0, 1'b1); send_pix(1, 1'b1); send_pix(2, 1'b1); send_pix(1, 1'b1);
    send_pix(3, 1'b1); send_pix(4, 1'b1); send_pix(1, 1'b1); send_pix(5, 1'b1);
    end_frame(1'b0);
    read_bins(256, 1'b0, -1);
    chk("throughput", 64'(acc_cyc[255] - acc_cyc[0]), 64'd765);
    chk("ref_bin0", 64'(obs_a[0]), 64'd1);
    chk("ref_bin1", 64'(obs_a[1]), 64'd4);
    chk("ref_bin2", 64'(obs_a[2]), 64'd5);
    chk("ref_bin3", 64'(obs_a[3]), 64'd6);
    chk("ref_bin4", 64'(obs_a[4]), 64'd7);
    chk("ref_bin5", 64'(obs_a[5]), 64'd8);
    chk("ref_bin6", 64'(obs_a[6]), 64'd8);
    chk("ref_bin255", 64'(obs_a[255]), 64'd8);

    // Random frame into the other bank with a 10-cycle stall on bin 3.
    start_frame();
    rand_frame(40);
    end_frame(1'b0);
    read_bins(256, 1'b0, 3);

    // frame_start coincident with frame_end closes the frame and stays idle.
    start_frame();
    rand_frame(30);
    cdf_ready = 1'b0;
    end_frame(1'b1);
    send_pix(9, 1'b1);
    read_bins(256, 1'b1, -1);

    // Overrun: a second frame closes while the first is still being read out.
    start_frame();
    rand_frame(25);
    end_frame(1'b0);
    read_bins(40, 1'b0, -1);
    cdf_ready = 1'b0;
    start_frame();
    rand_frame(25);
    end_frame(1'b0);
    read_bins(256, 1'b1, -1);
    start_frame();
    rand_frame(25);
    end_frame(1'b0);
    read_bins(256, 1'b0, -1);

    // Reset in the middle of a readout, then a clean frame from bin 0.
    start_frame();
    rand_frame(20);
    end_frame(1'b0);
    read_bins(100, 1'b0, -1);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    exp_base = 0; exp_busy = 1'b0; exp_overrun = 1'b0; armed = 1'b0; got = 0;
    start_frame();
    rand_frame(20);
    chk("no_valid_after_rst", {63'd0, cdf_valid}, 64'd0);
    end_frame(1'b0);
    read_bins(256, 1'b1, -1);

    // Saturation: every bin full scale.
    fill(65535);
    start_frame();
    end_frame(1'b0);
    read_bins(256, 1'b0, -1);
    chk("sat16_bin0", 64'(obs_b[0]), 64'd65535);
    chk("sat16_bin1", 64'(obs_b[1]), 64'd65535);
    chk("sat16_bin255", 64'(obs_b[255]), 64'd65535);
    chk("wide_bin255", 64'(obs_a[255]), 64'd16776960);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
